// File: rtl/branch_predictor.sv
// branch_predictor: bimodal/gshare 2-bit direction predictor with a direct-mapped BTB and saturating perf counters
module branch_predictor #(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 8,
  parameter int MODE    = 0,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       en,
  input  logic [DATA_W-1:0]          lookup_pc,
  output logic                       pred_taken,
  output logic [DATA_W-1:0]          pred_target,
  output logic                       pred_hit,
  output logic [$clog2(ENTRIES)-1:0] pred_ghr,
  input  logic                       update_valid,
  input  logic [DATA_W-1:0]          update_pc,
  input  logic [$clog2(ENTRIES)-1:0] update_ghr,
  input  logic                       update_taken,
  input  logic [DATA_W-1:0]          update_target,
  input  logic                       update_mispredict,
  output logic [CNT_W-1:0]           perf_updates,
  output logic [CNT_W-1:0]           perf_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  logic [1:0]        cnt     [ENTRIES];
  logic [TAG_W-1:0]  tag_mem [ENTRIES];
  logic [DATA_W-1:0] tgt_mem [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic [IDX_W-1:0]  ghr, l_idx, u_idx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic [1:0]        u_cnt;
  logic              upd, unused_bits;
  assign upd         = en && update_valid;
  assign l_idx       = lookup_pc[IDX_W+1:2] ^ (MODE == 1 ? ghr : '0);
  assign u_idx       = update_pc[IDX_W+1:2] ^ (MODE == 1 ? update_ghr : '0);
  assign l_tag       = lookup_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign u_tag       = update_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign u_cnt       = cnt[u_idx];
  assign pred_hit    = valid[l_idx] && tag_mem[l_idx] == l_tag;
  assign pred_taken  = pred_hit && cnt[l_idx][1];
  assign pred_target = pred_taken ? tgt_mem[l_idx] : lookup_pc + DATA_W'(4);
  assign pred_ghr    = ghr;
  assign unused_bits = ^{update_pc, update_ghr};
  // direction counters, valid bits, history and perf counters; reset wins over an update
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= 2'b01;
      valid            <= '0;
      ghr              <= '0;
      perf_updates     <= '0;
      perf_mispredicts <= '0;
    end else if (upd) begin
      cnt[u_idx] <= update_taken ? (&u_cnt ? u_cnt : u_cnt + 2'b01) : (|u_cnt ? u_cnt - 2'b01 : u_cnt);
      if (update_taken) valid[u_idx] <= 1'b1;
      if (MODE == 1) ghr <= {ghr[IDX_W-2:0], update_taken};
      perf_updates <= &perf_updates ? perf_updates : perf_updates + CNT_W'(1);
      if (update_mispredict) perf_mispredicts <= &perf_mispredicts ? perf_mispredicts : perf_mispredicts + CNT_W'(1);
    end
  end
  // tag and target storage is never cleared; valid bits alone gate its use
  always_ff @(posedge clk) begin
    if (arst_n && upd && update_taken) begin
      tag_mem[u_idx] <= u_tag;
      tgt_mem[u_idx] <= update_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table vectors, directed corner sequences and a randomized run against a behavioural model
module tb_branch_predictor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        arst_n = 1'b0, en = 1'b0, uv = 1'b0, ut = 1'b0, um = 1'b0;
  logic [63:0] upc = '0, utg = '0, lpc = '0;
  logic [4:0]  ugh = '0;
  logic        h [3];
  logic        t [3];
  logic [63:0] tg [3];
  logic [4:0]  g [3];
  logic [31:0] pu0, pm0, pu1, pm1;
  logic [3:0]  pu2, pm2;
  int errs = 0, checks = 0;

  branch_predictor d0 (.clk(clk), .arst_n(arst_n), .en(en), .lookup_pc(lpc), .pred_taken(t[0]), .pred_target(tg[0]),
    .pred_hit(h[0]), .pred_ghr(g[0]), .update_valid(uv), .update_pc(upc), .update_ghr(ugh), .update_taken(ut),
    .update_target(utg), .update_mispredict(um), .perf_updates(pu0), .perf_mispredicts(pm0));
  branch_predictor #(.MODE(1)) d1 (.clk(clk), .arst_n(arst_n), .en(en), .lookup_pc(lpc), .pred_taken(t[1]), .pred_target(tg[1]),
    .pred_hit(h[1]), .pred_ghr(g[1]), .update_valid(uv), .update_pc(upc), .update_ghr(ugh), .update_taken(ut),
    .update_target(utg), .update_mispredict(um), .perf_updates(pu1), .perf_mispredicts(pm1));
  branch_predictor #(.CNT_W(4)) d2 (.clk(clk), .arst_n(arst_n), .en(en), .lookup_pc(lpc), .pred_taken(t[2]), .pred_target(tg[2]),
    .pred_hit(h[2]), .pred_ghr(g[2]), .update_valid(uv), .update_pc(upc), .update_ghr(ugh), .update_taken(ut),
    .update_target(utg), .update_mispredict(um), .perf_updates(pu2), .perf_mispredicts(pm2));

  typedef struct {
    logic e, v, tk, m;
    logic [63:0] p, tgt, l;
    logic eh, et;
    logic [63:0] etg;
  } vec_t;
  vec_t tbl [17];

  int          mc   [3][32];
  bit          mv   [3][32];
  int          mtag [3][32];
  logic [63:0] mtg  [3][32];
  int          mg   [3];
  longint      mu   [3];
  longint      mm   [3];

  function automatic vec_t mk(logic e, logic v, logic tk, logic m, logic [63:0] p, logic [63:0] tgt, logic [63:0] l,
                              logic eh, logic et, logic [63:0] etg);
    vec_t r;
    r.e = e; r.v = v; r.tk = tk; r.m = m; r.p = p; r.tgt = tgt; r.l = l; r.eh = eh; r.et = et; r.etg = etg;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0; en = 1'b0; uv = 1'b0; um = 1'b0;
    @(negedge clk);
    arst_n = 1'b1; en = 1'b1;
  endtask

  function automatic int midx(int k, logic [63:0] pc, int gh);
    return int'(pc[6:2]) ^ (k == 1 ? gh : 0);
  endfunction

  function automatic logic [63:0] perf_u(int k);
    return k == 0 ? 64'(pu0) : k == 1 ? 64'(pu1) : 64'(pu2);
  endfunction

  function automatic logic [63:0] perf_m(int k);
    return k == 0 ? 64'(pm0) : k == 1 ? 64'(pm1) : 64'(pm2);
  endfunction

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) begin
        mc[k][i] = 1;
        mv[k][i] = 1'b0;
      end
      mg[k] = 0; mu[k] = 0; mm[k] = 0;
    end
  endtask

  task automatic mstep();
    if (!arst_n) mreset();
    else if (en && uv) begin
      for (int k = 0; k < 3; k++) begin
        int i;
        longint cap;
        cap = k == 2 ? 64'd15 : 64'd4294967295;
        i = midx(k, upc, int'(ugh));
        mc[k][i] = ut ? (mc[k][i] == 3 ? 3 : mc[k][i] + 1) : (mc[k][i] == 0 ? 0 : mc[k][i] - 1);
        if (ut) begin
          mv[k][i] = 1'b1;
          mtag[k][i] = int'(upc[14:7]);
          mtg[k][i] = utg;
        end
        if (k == 1) mg[k] = ((mg[k] << 1) | int'(ut)) % 32;
        if (mu[k] < cap) mu[k]++;
        if (um && mm[k] < cap) mm[k]++;
      end
    end
  endtask

  task automatic mcheck();
    for (int k = 0; k < 3; k++) begin
      int i;
      logic eh, et;
      logic [63:0] etg;
      i = midx(k, lpc, mg[k]);
      eh = mv[k][i] && mtag[k][i] == int'(lpc[14:7]);
      et = eh && mc[k][i] >= 2;
      etg = et ? mtg[k][i] : lpc + 64'd4;
      chk($sformatf("rnd_d%0d_hit_taken_ghr", k), {h[k], t[k], g[k]}, {eh, et, 5'(mg[k])});
      chk($sformatf("rnd_d%0d_target", k), tg[k], etg);
      chk($sformatf("rnd_d%0d_perf_updates", k), perf_u(k), mu[k]);
      chk($sformatf("rnd_d%0d_perf_mispredicts", k), perf_m(k), mm[k]);
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 64'h0,   64'h0,   64'h100, 0, 0, 64'h104);
    tbl[1]  = mk(1, 1, 1, 1, 64'h100, 64'h200, 64'h100, 0, 0, 64'h104);
    tbl[2]  = mk(1, 1, 1, 0, 64'h100, 64'h200, 64'h100, 1, 1, 64'h200);
    tbl[3]  = mk(1, 1, 1, 0, 64'h100, 64'h200, 64'h100, 1, 1, 64'h200);
    tbl[4]  = mk(1, 1, 1, 0, 64'h100, 64'h200, 64'h100, 1, 1, 64'h200);
    tbl[5]  = mk(1, 1, 0, 1, 64'h100, 64'h200, 64'h100, 1, 1, 64'h200);
    tbl[6]  = mk(1, 1, 0, 0, 64'h100, 64'h200, 64'h100, 1, 1, 64'h200);
    tbl[7]  = mk(1, 1, 0, 0, 64'h100, 64'h200, 64'h100, 1, 0, 64'h104);
    tbl[8]  = mk(1, 0, 0, 0, 64'h0,   64'h0,   64'h100, 1, 0, 64'h104);
    tbl[9]  = mk(1, 0, 0, 0, 64'h0,   64'h0,   64'h180, 0, 0, 64'h184);
    tbl[10] = mk(0, 1, 1, 0, 64'h180, 64'h300, 64'h100, 1, 0, 64'h104);
    tbl[11] = mk(1, 0, 0, 0, 64'h0,   64'h0,   64'h180, 0, 0, 64'h184);
    tbl[12] = mk(1, 1, 1, 0, 64'h180, 64'h300, 64'h180, 0, 0, 64'h184);
    tbl[13] = mk(1, 0, 0, 0, 64'h0,   64'h0,   64'h180, 1, 0, 64'h184);
    tbl[14] = mk(1, 0, 0, 0, 64'h0,   64'h0,   64'h100, 0, 0, 64'h104);
    tbl[15] = mk(1, 1, 1, 0, 64'h180, 64'h300, 64'h180, 1, 0, 64'h184);
    tbl[16] = mk(1, 0, 0, 0, 64'h0,   64'h0,   64'h180, 1, 1, 64'h300);
    @(negedge clk);
    do_reset();
    lpc = 64'h100;
    #1;
    chk("reset_perf_updates", 64'(pu0), 64'd0);
    chk("reset_ghr_mode1", 64'(g[1]), 64'd0);
    for (int i = 0; i < 17; i++) begin
      en = tbl[i].e; uv = tbl[i].v; ut = tbl[i].tk; um = tbl[i].m;
      upc = tbl[i].p; utg = tbl[i].tgt; lpc = tbl[i].l; ugh = '0;
      #1;
      chk($sformatf("vec%0d_hit", i), 64'(h[0]), 64'(tbl[i].eh));
      chk($sformatf("vec%0d_taken", i), 64'(t[0]), 64'(tbl[i].et));
      chk($sformatf("vec%0d_target", i), tg[0], tbl[i].etg);
      @(negedge clk);
    end
    en = 1'b1; uv = 1'b0;
    #1;
    chk("vec_perf_updates", 64'(pu0), 64'd9);
    chk("vec_perf_mispredicts", 64'(pm0), 64'd2);
    @(negedge clk);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      uv = 1'b1; ut = 1'b1; um = 1'b0; upc = 64'h100; utg = 64'h200; ugh = 5'((1 << k) - 1); lpc = 64'h100;
      #1;
      chk($sformatf("gshare_ghr_before_upd%0d", k), 64'(g[1]), 64'((1 << k) - 1));
      @(negedge clk);
    end
    uv = 1'b1; ut = 1'b1; upc = 64'h40; utg = 64'h5000; ugh = 5'd7; lpc = 64'h40;
    #1;
    chk("gshare_ghr_after_three", 64'(g[1]), 64'h7);
    chk("gshare_same_cycle_old", {h[1], t[1]}, 64'd0);
    chk("gshare_same_cycle_old_target", tg[1], 64'h44);
    @(negedge clk);
    uv = 1'b0; lpc = 64'h60;
    #1;
    chk("gshare_ghr_after_four", 64'(g[1]), 64'hf);
    chk("gshare_next_cycle_new", {h[1], t[1]}, 64'd3);
    chk("gshare_next_cycle_target", tg[1], 64'h5000);
    chk("bimodal_ghr_zero", 64'(g[0]), 64'd0);
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      uv = 1'b1; um = 1'b1; ut = 1'($urandom); upc = 64'h100; utg = 64'h200;
      @(negedge clk);
    end
    uv = 1'b0;
    #1;
    chk("sat4_perf_updates", 64'(pu2), 64'd15);
    chk("sat4_perf_mispredicts", 64'(pm2), 64'd15);
    chk("wide_perf_updates", 64'(pu0), 64'd20);
    @(negedge clk);
    en = 1'b0; uv = 1'b1; um = 1'b1; ut = 1'b1; upc = 64'h800; utg = 64'h900; lpc = 64'h800;
    @(negedge clk);
    en = 1'b1; uv = 1'b0;
    #1;
    chk("en0_perf_updates", 64'(pu0), 64'd20);
    chk("en0_perf_mispredicts", 64'(pm0), 64'd20);
    chk("en0_no_btb_write", 64'(h[0]), 64'd0);
    @(negedge clk);
    arst_n = 1'b0; en = 1'b1; uv = 1'b1; ut = 1'b1; um = 1'b1; upc = 64'h100; utg = 64'h200;
    @(negedge clk);
    arst_n = 1'b1; uv = 1'b0; lpc = 64'h100;
    #1;
    chk("midreset_perf_updates", 64'(pu0), 64'd0);
    chk("midreset_perf_mispredicts", 64'(pm2), 64'd0);
    chk("midreset_hit", {h[0], t[0], h[1]}, 64'd0);
    chk("midreset_target", tg[0], 64'h104);
    @(negedge clk);

    do_reset();
    mreset();
    for (int n = 0; n < 600; n++) begin
      arst_n = $urandom_range(0, 99) != 0;
      en = $urandom_range(0, 9) != 0;
      uv = $urandom_range(0, 3) != 0;
      ut = 1'($urandom);
      um = 1'($urandom);
      ugh = 5'($urandom);
      upc = $urandom_range(0, 7) == 0 ? {$urandom, $urandom} : 64'($urandom_range(0, 1023)) << 2;
      utg = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: lpc = upc;
        1: lpc = 64'hffff_ffff_ffff_fffc;
        default: lpc = 64'($urandom_range(0, 1023)) << 2;
      endcase
      #1;
      mcheck();
      @(posedge clk);
      mstep();
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
